// File: rtl/bcd_counter_display_if.sv
// Button inputs and display/LED outputs of the BCD counter, bundled for board-level wiring.
// The counter side uses the slave modport; the board or bench side uses master.
interface bcd_counter_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    btn_up;
    logic                    btn_down;
    logic                    btn_clear;
    logic [4*NUM_DIGITS-1:0] value;
    logic [3:0]              led;
    logic                    wrap;
    logic [6:0]              cathodes;
    logic [NUM_DIGITS-1:0]   anodes;

    modport master (
        output btn_up, btn_down, btn_clear,
        input  value, led, wrap, cathodes, anodes
    );

    modport slave (
        input  btn_up, btn_down, btn_clear,
        output value, led, wrap, cathodes, anodes
    );
endinterface

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with debounced push-buttons and a multiplexed
// common-anode 7-segment display with optional leading-zero blanking.
module bcd_counter_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REFRESH_CYCLES  = 16384,
    parameter bit BLANK_LEADING   = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_counter_display_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    // Button vectors are ordered {clear, down, up}.
    logic [2:0]            sync1, sync2, sample, prev, armed, press;
    logic [1:0]            fill;
    logic [DW-1:0]         deb_cnt;
    logic                  tick, tick_d;
    logic [VW-1:0]         value, inc_value, dec_value;
    logic                  carry, borrow, wrap;
    logic [RW-1:0]         ref_cnt;
    logic [IW-1:0]         scan_idx;
    logic [NUM_DIGITS-1:0] anodes, blank;
    logic [6:0]            cathodes;
    logic [3:0]            cur_digit;
    logic                  upper_zero;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign tick  = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign press = {3{tick_d}} & sample & ~prev & armed;

    // A button becomes armed only once it has been seen released after reset,
    // so a button held through reset cannot produce a press on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sample  <= '0;
            prev    <= '0;
            armed   <= '0;
            fill    <= '0;
            deb_cnt <= '0;
            tick_d  <= 1'b0;
        end else begin
            sync1   <= {bus.btn_clear, bus.btn_down, bus.btn_up};
            sync2   <= sync1;
            deb_cnt <= tick ? '0 : deb_cnt + DW'(1);
            tick_d  <= tick;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end else begin
                armed <= armed | ~sync2;
            end
            if (tick) begin
                sample <= sync2;
                prev   <= sample;
            end
        end
    end

    always_comb begin
        inc_value = value;
        dec_value = value;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (value[4*k +: 4] == 4'd9) begin
                    inc_value[4*k +: 4] = 4'd0;
                end else begin
                    inc_value[4*k +: 4] = value[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value[4*k +: 4] == 4'd0) begin
                    dec_value[4*k +: 4] = 4'd9;
                end else begin
                    dec_value[4*k +: 4] = value[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Clear dominates; simultaneous up and down cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (press[2]) begin
                value <= '0;
            end else if (press[0] && !press[1]) begin
                value <= inc_value;
                wrap  <= carry;
            end else if (press[1] && !press[0]) begin
                value <= dec_value;
                wrap  <= borrow;
            end
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (value[4*k +: 4] == 4'd0);
            blank[k]   = BLANK_LEADING && (k > 0) && upper_zero;
        end
    end

    assign cur_digit = value[int'(scan_idx)*4 +: 4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            anodes   <= ~NUM_DIGITS'(1);
            cathodes <= 7'b1000000;
        end else begin
            if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
                ref_cnt  <= '0;
                scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            anodes   <= ~(NUM_DIGITS'(1) << scan_idx);
            cathodes <= blank[scan_idx] ? 7'b1111111 : seg7(cur_digit);
        end
    end

    assign bus.value    = value;
    assign bus.led      = value[3:0];
    assign bus.wrap     = wrap;
    assign bus.cathodes = cathodes;
    assign bus.anodes   = anodes;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display: table vectors, corner sequences and
// randomized presses checked against an integer model of the counter and display.
module tb_bcd_counter_display;
    localparam int ND = 4;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    typedef struct {
        logic        up;
        logic        down;
        logic        clear;
        logic [15:0] exp_value;
        int          exp_wraps;
    } vec_t;

    logic clk;
    logic rst_n;
    int   pass_count;
    int   check_count;
    int   wrap_seen;
    int   model;
    vec_t vecs [10];

    bcd_counter_display_if #(.NUM_DIGITS(ND)) bus ();
    bcd_counter_display_if #(.NUM_DIGITS(ND)) bus_nb ();

    assign bus_nb.btn_up    = bus.btn_up;
    assign bus_nb.btn_down  = bus.btn_down;
    assign bus_nb.btn_clear = bus.btn_clear;

    bcd_counter_display #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(2), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    bcd_counter_display #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(2), .BLANK_LEADING(1'b0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .bus(bus_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input int v, input int k);
        return (v / pow10(k)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'(digit_of(v, k));
        return r;
    endfunction

    // Counter semantics as plain modular arithmetic on the decimal count.
    function automatic int model_apply(input logic up, input logic down, input logic clear);
        int wraps;
        wraps = 0;
        if (clear) begin
            model = 0;
        end else if (up && !down) begin
            wraps = (model == 9999) ? 1 : 0;
            model = (model + 1) % 10000;
        end else if (down && !up) begin
            wraps = (model == 0) ? 1 : 0;
            model = (model + 9999) % 10000;
        end
        return wraps;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.wrap) wrap_seen++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic clear);
        wrap_seen     = 0;
        bus.btn_up    = up;
        bus.btn_down  = down;
        bus.btn_clear = clear;
        repeat (8) step();
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (8) step();
    endtask

    task automatic press_n(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            w = model_apply(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        model = 0;
    endtask

    task automatic checkDisplay(input int cycles);
        int prev_idx, run, runs_done;
        prev_idx  = -1;
        run       = 0;
        runs_done = 0;
        repeat (4) step();
        for (int c = 0; c < cycles; c++) begin
            int idx, idx_nb, zeros;
            logic [6:0] exp;
            step();
            zeros  = 0;
            idx    = 0;
            idx_nb = 0;
            for (int k = 0; k < ND; k++) begin
                if (!bus.anodes[k]) begin
                    zeros++;
                    idx = k;
                end
                if (!bus_nb.anodes[k]) idx_nb = k;
            end
            checkOutput("anode_onehot", 32'(zeros), 32'd1);
            exp = (idx > 0 && model / pow10(idx) == 0) ? 7'h7F : SEG[digit_of(model, idx)];
            checkOutput("cathodes_blank", 32'(bus.cathodes), 32'(exp));
            checkOutput("cathodes_noblank", 32'(bus_nb.cathodes), 32'(SEG[digit_of(model, idx_nb)]));
            if (idx != prev_idx) begin
                if (prev_idx >= 0) begin
                    checkOutput("scan_order", 32'(idx), 32'((prev_idx + 1) % ND));
                    if (runs_done > 0) checkOutput("slot_length", 32'(run), 32'd2);
                    runs_done++;
                end
                prev_idx = idx;
                run      = 1;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        int w;
        pass_count    = 0;
        check_count   = 0;
        wrap_seen     = 0;
        model         = 0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_clear = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h9999, 1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0001, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h9999, 1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h0000, 0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h9999, 1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0};

        do_reset();
        checkOutput("reset_value", 32'(bus.value), 32'h0);
        checkOutput("reset_led", 32'(bus.led), 32'h0);
        checkOutput("reset_wrap", 32'(bus.wrap), 32'h0);
        checkOutput("reset_anodes", 32'(bus.anodes), 32'hE);
        checkOutput("reset_cathodes", 32'(bus.cathodes), 32'h40);

        // Held press: tick edge five cycles after press start, value one clk later.
        repeat (3) step();
        wrap_seen  = 0;
        bus.btn_up = 1'b1;
        repeat (5) step();
        checkOutput("before_tick_value", 32'(bus.value), 32'h0);
        step();
        checkOutput("after_tick_value", 32'(bus.value), 32'h1);
        repeat (34) step();
        checkOutput("held_value", 32'(bus.value), 32'h1);
        checkOutput("held_led", 32'(bus.led), 32'h1);
        checkOutput("held_no_wrap", 32'(wrap_seen), 32'd0);
        bus.btn_up = 1'b0;
        repeat (8) step();
        model = 1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].up, vecs[i].down, vecs[i].clear);
            w = model_apply(vecs[i].up, vecs[i].down, vecs[i].clear);
            checkOutput("vec_value", 32'(bus.value), 32'(vecs[i].exp_value));
            checkOutput("vec_wraps", 32'(wrap_seen), 32'(vecs[i].exp_wraps));
        end

        press_n(9);
        checkOutput("nine_value", 32'(bus.value), 32'h0009);
        applyStimulus(1'b1, 1'b0, 1'b0);
        w = model_apply(1'b1, 1'b0, 1'b0);
        checkOutput("carry_value", 32'(bus.value), 32'h0010);
        checkOutput("carry_no_wrap", 32'(wrap_seen), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        w = model_apply(1'b0, 1'b0, 1'b1);
        press_n(42);
        checkOutput("v42_value", 32'(bus.value), 32'h0042);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("updown_value", 32'(bus.value), 32'h0042);
        applyStimulus(1'b1, 1'b1, 1'b1);
        w = model_apply(1'b1, 1'b1, 1'b1);
        checkOutput("all3_value", 32'(bus.value), 32'h0000);
        checkOutput("all3_wraps", 32'(wrap_seen), 32'd0);

        press_n(100);
        checkOutput("v100_value", 32'(bus.value), 32'h0100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        w = model_apply(1'b0, 1'b1, 1'b0);
        checkOutput("borrow_value", 32'(bus.value), 32'h0099);

        applyStimulus(1'b0, 1'b0, 1'b1);
        w = model_apply(1'b0, 1'b0, 1'b1);
        press_n(7);
        checkOutput("v7_value", 32'(bus.value), 32'h0007);
        checkDisplay(16);

        // Bounce: a few single-cycle toggles before settling high.
        bus.btn_up = 1'b1;
        step();
        bus.btn_up = 1'b0;
        step();
        bus.btn_up = 1'b1;
        step();
        repeat (8) step();
        bus.btn_up = 1'b0;
        repeat (8) step();
        w = model_apply(1'b1, 1'b0, 1'b0);
        checkOutput("bounce_value", 32'(bus.value), 32'(to_bcd(model)));

        for (int i = 0; i < 40; i++) begin
            int r, ew;
            logic up, down, clear;
            r     = int'($urandom_range(0, 9));
            up    = (r <= 3) || (r == 9);
            down  = (r >= 4 && r <= 7) || (r == 9);
            clear = (r == 8);
            applyStimulus(up, down, clear);
            ew = model_apply(up, down, clear);
            checkOutput("rand_value", 32'(bus.value), 32'(to_bcd(model)));
            checkOutput("rand_led", 32'(bus.led), 32'(digit_of(model, 0)));
            checkOutput("rand_wraps", 32'(wrap_seen), 32'(ew));
            if (i % 10 == 9) checkDisplay(10);
        end

        // Button held across reset must not count until released and pressed again.
        bus.btn_down = 1'b1;
        do_reset();
        repeat (20) step();
        checkOutput("held_reset_value", 32'(bus.value), 32'h0);
        bus.btn_down = 1'b0;
        repeat (8) step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        w = model_apply(1'b0, 1'b1, 1'b0);
        checkOutput("repress_value", 32'(bus.value), 32'h9999);
        checkOutput("repress_wraps", 32'(wrap_seen), 32'(w));

        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("midscan_value", 32'(bus.value), 32'h0);
        checkOutput("midscan_anodes", 32'(bus.anodes), 32'hE);
        checkOutput("midscan_cathodes", 32'(bus.cathodes), 32'h40);
        checkOutput("midscan_led", 32'(bus.led), 32'h0);
        checkOutput("midscan_wrap", 32'(bus.wrap), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
